// File: rtl/tap_window_monitor_pkg.sv
// Shared types and defaults for the tap window monitor.
package tap_window_monitor_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int WINDOW_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Result buffer layout; fields are sized for the widest supported CNT_W.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] mismatch;
    logic [CNT_W_DEF-1:0] edges0;
    logic [CNT_W_DEF-1:0] edges1;
  } win_res_t;

endpackage

// File: rtl/tap_window_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // q_o already includes this cycle's increment so a closing window can
  // capture its final value on the same edge that clears the counter.
  assign cnt_d = (inc_i && (cnt_q != '1)) ? cnt_q + W'(1) : cnt_q;
  assign q_o   = cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tap_window_monitor.sv
// Windowed statistics on two registered taps with a valid/ready result buffer.
module tap_window_monitor
  import tap_window_monitor_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF   // must not exceed CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             en,
  input  logic             tap0,
  input  logic             tap1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_mismatch,
  output logic [CNT_W-1:0] res_edges0,
  output logic [CNT_W-1:0] res_edges1,
  output logic             overrun
);

  localparam int              WC_W  = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WLAST = WC_W'(WINDOW - 1);

  state_e          state_q;
  logic            s0_q, s1_q, p0_q, p1_q;
  logic [WC_W-1:0] wcnt_q;
  win_res_t        buf_q;
  logic            valid_q, ovr_q;

  logic                       counted, close, clr;
  logic [2:0]                 inc;
  logic [2:0][CNT_W-1:0]      cnt;

  assign counted = (state_q == RUN) && en;
  assign close   = counted && (wcnt_q == WLAST);
  assign clr     = close || ((state_q == RUN) && !en);

  assign inc[0] = counted && (s0_q ^ s1_q);
  assign inc[1] = counted && s0_q && !p0_q;
  assign inc[2] = counted && s1_q && !p1_q;

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i  (CLK),
      .rst_ni (ASYNCRESETN),
      .inc_i  (inc[g]),
      .clr_i  (clr),
      .q_o    (cnt[g])
    );
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      p0_q    <= 1'b0;
      p1_q    <= 1'b0;
      wcnt_q  <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s0_q <= tap0;
      s1_q <= tap1;
      p0_q <= s0_q;
      p1_q <= s1_q;

      case (state_q)
        IDLE: if (en) state_q <= RUN;
        RUN: begin
          if (!en) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
          end else begin
            wcnt_q <= close ? '0 : wcnt_q + WC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // A close with a pending unread result loads only if the reader
      // takes the old one on this very edge; otherwise the new one is lost.
      if (close && (!valid_q || res_ready)) begin
        buf_q.mismatch <= CNT_W_DEF'(cnt[0]);
        buf_q.edges0   <= CNT_W_DEF'(cnt[1]);
        buf_q.edges1   <= CNT_W_DEF'(cnt[2]);
        valid_q        <= 1'b1;
      end else if (close) begin
        ovr_q <= 1'b1;
      end else if (valid_q && res_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign res_valid    = valid_q;
  assign res_mismatch = buf_q.mismatch[CNT_W-1:0];
  assign res_edges0   = buf_q.edges0[CNT_W-1:0];
  assign res_edges1   = buf_q.edges1[CNT_W-1:0];
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_tap_window_monitor.sv
// Bench: directed vector table, saturation/async-reset sequence, random vs. model.
module tb_tap_window_monitor;

  localparam int WA  = 4;
  localparam int CWA = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic           rst_a = 1'b1, en_a = 1'b0, t0_a = 1'b0, t1_a = 1'b0, rdy_a = 1'b0;
  logic           v_a, ovr_a;
  logic [CWA-1:0] mis_a, e0_a, e1_a;

  logic           rst_b = 1'b1, en_b = 1'b0, t0_b = 1'b0, t1_b = 1'b0, rdy_b = 1'b0;
  logic           v_b, ovr_b;
  logic [1:0]     mis_b, e0_b, e1_b;

  tap_window_monitor #(.WINDOW(WA), .CNT_W(CWA)) dut_a (
    .CLK(CLK), .ASYNCRESETN(rst_a), .en(en_a), .tap0(t0_a), .tap1(t1_a),
    .res_valid(v_a), .res_ready(rdy_a), .res_mismatch(mis_a),
    .res_edges0(e0_a), .res_edges1(e1_a), .overrun(ovr_a));

  tap_window_monitor #(.WINDOW(8), .CNT_W(2)) dut_b (
    .CLK(CLK), .ASYNCRESETN(rst_b), .en(en_b), .tap0(t0_b), .tap1(t1_b),
    .res_valid(v_b), .res_ready(rdy_b), .res_mismatch(mis_b),
    .res_edges0(e0_b), .res_edges1(e1_b), .overrun(ovr_b));

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(string nm, bit v, int mis, int e0, int e1, bit ovr);
    chk({nm, ".valid"},    32'(v_a),   32'(v));
    chk({nm, ".mismatch"}, 32'(mis_a), mis);
    chk({nm, ".edges0"},   32'(e0_a),  e0);
    chk({nm, ".edges1"},   32'(e1_a),  e1);
    chk({nm, ".overrun"},  32'(ovr_a), 32'(ovr));
  endtask

  // ---------------- reference model (DUT A) ----------------
  typedef struct { bit s0, s1, p0, p1; } smp_t;
  smp_t win[$];
  bit   m_s0, m_s1, m_p0, m_p1, m_run, m_valid, m_ovr;
  int   m_res[3];

  function automatic int sat(int x);
    return (x > (1 << CWA) - 1) ? (1 << CWA) - 1 : x;
  endfunction

  task automatic m_reset();
    win.delete();
    {m_s0, m_s1, m_p0, m_p1, m_run, m_valid, m_ovr} = '0;
    m_res = '{0, 0, 0};
  endtask

  // Window = list of register samples seen on counted cycles; stats are
  // recomputed from that list when it fills.
  task automatic m_step(bit en, bit t0, bit t1, bit rdy);
    bit close = 1'b0;
    if (!en) win.delete();
    else if (m_run) begin
      win.push_back('{m_s0, m_s1, m_p0, m_p1});
      close = (win.size() == WA);
    end
    if (close) begin
      if (!m_valid || rdy) begin
        int c0 = 0, c1 = 0, c2 = 0;
        foreach (win[i]) begin
          c0 += int'(win[i].s0 != win[i].s1);
          c1 += int'(win[i].s0 && !win[i].p0);
          c2 += int'(win[i].s1 && !win[i].p1);
        end
        m_res = '{sat(c0), sat(c1), sat(c2)};
        m_valid = 1'b1;
      end else m_ovr = 1'b1;
      win.delete();
    end else if (m_valid && rdy) m_valid = 1'b0;
    m_run = en;
    m_p0 = m_s0; m_p1 = m_s1;
    m_s0 = t0;   m_s1 = t1;
  endtask

  task automatic drive_a(bit en, bit t0, bit t1, bit rdy);
    @(negedge CLK);
    en_a = en; t0_a = t0; t1_a = t1; rdy_a = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_a();
    @(negedge CLK);
    en_a = 0; t0_a = 0; t1_a = 0; rdy_a = 0;
    rst_a = 0;
    #1 rst_a = 1;
    m_reset();
  endtask

  task automatic drive_b(bit en, bit t0, bit t1, bit rdy);
    @(negedge CLK);
    en_b = en; t0_b = t0; t1_b = t1; rdy_b = rdy;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- directed vector table (DUT A) ----------------
  typedef struct {
    bit rst, en, t0, t1, rdy;
    bit v; int mis, e0, e1; bit ovr;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit en, bit t0, bit t1, bit rdy,
                              bit v, int mis, int e0, int e1, bit ovr);
    tbl.push_back('{rst, en, t0, t1, rdy, v, mis, e0, e1, ovr});
  endfunction

  initial begin
    // basic window, then an overrun while the reader stalls, then drain
    add(1,1,1,1,0, 0,0,0,0,0); add(0,1,0,0,0, 0,0,0,0,0);
    add(0,1,1,0,0, 0,0,0,0,0); add(0,1,0,1,0, 0,0,0,0,0);
    add(0,1,0,0,0, 1,2,2,2,0);
    for (int i = 0; i < 3; i++) add(0,1,0,0,0, 1,2,2,2,0);
    add(0,1,0,0,0, 1,2,2,2,1); add(0,0,0,0,1, 0,2,2,2,1);
    // back-to-back with ready high, then close and accept on the same edge
    add(1,1,1,1,1, 0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,1, 0,0,0,0,0);
    add(0,1,1,1,1, 1,0,1,1,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,1, 0,0,1,1,0);
    add(0,1,0,1,1, 1,0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,1,0,1,0, 1,0,0,0,0);
    add(0,1,0,0,1, 1,4,0,0,0);
    // en drops after two counted cycles; only the later full window counts
    add(1,1,1,0,0, 0,0,0,0,0); add(0,1,1,0,0, 0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0); add(0,0,0,1,0, 0,0,0,0,0);
    add(0,1,0,1,0, 0,0,0,0,0); add(0,1,1,1,0, 0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0); add(0,1,1,0,0, 0,0,0,0,0);
    add(0,1,0,0,0, 1,2,2,0,0);

    #1 rst_a = 0; rst_b = 0;
    #1 chk_a("reset_a", 0, 0, 0, 0, 0);
    chk("reset_b", 32'({v_b, mis_b, e0_b, e1_b, ovr_b}), 0);
    @(negedge CLK); rst_a = 1; rst_b = 1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) reset_a();
      drive_a(tbl[i].en, tbl[i].t0, tbl[i].t1, tbl[i].rdy);
      chk_a($sformatf("row%0d", i), tbl[i].v, tbl[i].mis, tbl[i].e0, tbl[i].e1, tbl[i].ovr);
    end

    // saturation on a 2-bit counter, overrun, then async reset between edges
    for (int k = 0; k <= 16; k++) begin
      drive_b(1, 1, 0, 0);
      if (k == 7) chk("sat_pre_close.valid", 32'(v_b), 0);
      if (k == 8) begin
        chk("sat.valid",    32'(v_b),   1);
        chk("sat.mismatch", 32'(mis_b), 3);
        chk("sat.edges0",   32'(e0_b),  1);
        chk("sat.edges1",   32'(e1_b),  0);
        chk("sat.overrun",  32'(ovr_b), 0);
      end
    end
    chk("sat_ovr.overrun",  32'(ovr_b), 1);
    chk("sat_ovr.mismatch", 32'(mis_b), 3);
    chk("sat_ovr.edges0",   32'(e0_b),  1);
    drive_b(1, 1, 0, 0);
    #2 rst_b = 0;
    #1 chk("async_rst.outputs", 32'({v_b, mis_b, e0_b, e1_b, ovr_b}), 0);
    #1 rst_b = 1;
    drive_b(0, 0, 0, 0);
    chk("post_rst.outputs", 32'({v_b, mis_b, e0_b, e1_b, ovr_b}), 0);

    // randomized traffic against the model
    reset_a();
    for (int c = 0; c < 3000; c++) begin
      bit en, t0, t1, rdy;
      if ($urandom_range(299) == 0) reset_a();
      en  = ($urandom_range(9) != 0);
      t0  = 1'($urandom);
      t1  = 1'($urandom);
      rdy = 1'($urandom);
      drive_a(en, t0, t1, rdy);
      m_step(en, t0, t1, rdy);
      chk_a($sformatf("rnd%0d", c), m_valid, m_res[0], m_res[1], m_res[2], m_ovr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
